// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: widths, reset PC,
// NOP encoding, fetch FSM states and the IF/ID payload.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PIPE_RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    BUF   = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if;
  import if_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; a non-valid load is a bubble.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PIPE_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  ifid_t           load,
  output logic [XLEN-1:0] PC_01,
  output logic [XLEN-1:0] Instr_01,
  output logic            valid_01
);

  // Bubbles keep the last PC so a flushed slot still reports where it sat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_01    <= RESET_PC;
      Instr_01 <= NOP_INSTR;
      valid_01 <= 1'b0;
    end else if (flush) begin
      Instr_01 <= NOP_INSTR;
      valid_01 <= 1'b0;
    end else if (!stall) begin
      if (load.valid) begin
        PC_01    <= load.pc;
        Instr_01 <= load.instr;
        valid_01 <= 1'b1;
      end else begin
        Instr_01 <= NOP_INSTR;
        valid_01 <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC, one-entry skid buffer, delayed-branch redirect
// and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PIPE_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [XLEN-1:0]   NPC,
  if_stage_if.master        imem,
  output logic [XLEN-1:0]   PC_01,
  output logic [XLEN-1:0]   Instr_01,
  output logic              valid_01
);

  fetch_state_t    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] ptgt_q, ptgt_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  ifid_t           load;

  logic            ack_ok;
  logic            take_redir;
  logic            hold;
  logic [XLEN-1:0] adv_pc;

  assign ack_ok     = imem.imem_ack & req_q;
  assign take_redir = redirect & ~stall;
  assign hold       = stall | flush;
  assign adv_pc     = take_redir ? word_align(NPC)
                    : pend_q     ? ptgt_q
                    : fpc_q + XLEN'(4);

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = word_align(fpc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      req_q        <= 1'b0;
      fpc_q        <= word_align(RESET_PC);
      pend_q       <= 1'b0;
      ptgt_q       <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      fpc_q        <= fpc_d;
      pend_q       <= pend_d;
      ptgt_q       <= ptgt_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    pend_d       = pend_q;
    ptgt_d       = ptgt_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    load         = '0;

    if (take_redir) begin
      pend_d = 1'b1;
      ptgt_d = word_align(NPC);
    end

    case (state_q)
      FETCH: begin
        if (ack_ok) begin
          fpc_d  = adv_pc;
          pend_d = 1'b0;
          if (hold) begin
            skid_pc_d    = fpc_q;
            skid_instr_d = imem.imem_rdata;
            state_d      = BUF;
          end else begin
            load = '{pc: fpc_q, instr: imem.imem_rdata, valid: 1'b1};
          end
        end
      end
      BUF: begin
        // The delay slot already sits in the skid buffer, so a redirect here
        // retargets the fetch PC directly instead of waiting for an advance.
        if (take_redir) begin
          fpc_d  = word_align(NPC);
          pend_d = 1'b0;
        end
        if (!hold) begin
          load    = '{pc: skid_pc_q, instr: skid_instr_q, valid: 1'b1};
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    req_d = (state_d == FETCH);
  end

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .load     (load),
    .PC_01    (PC_01),
    .Instr_01 (Instr_01),
    .valid_01 (valid_01)
  );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-004 SHALL have port stall  input  1  hazard hold; IF/ID register and fetch PC keep their values.
REQ-005 SHALL have port flush  input  1  IF/ID register cleared to bubble at next edge.
REQ-006 SHALL have port redirect  input  1  branch/jump taken in ID; NPC valid.
REQ-007 SHALL have port NPC  input  32  redirect target from ID.
REQ-008 SHALL have port imem_req  output  1  instruction memory request.
REQ-009 SHALL have port imem_addr  output  32  word-aligned fetch address, stable while imem_req=1 and no ack.
REQ-010 SHALL have port imem_ack  input  1  one-cycle response strobe; imem_rdata valid in the same cycle.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-012 SHALL have port PC_01  output  32  PC of the instruction held in IF/ID.
REQ-013 SHALL have port Instr_01  output  32  instruction held in IF/ID; 0 (sll nop) when bubble.
REQ-014 SHALL have port valid_01  output  1  IF/ID holds a real instruction.

Function
REQ-015 SHALL keep a fetch PC (fpc) driving imem_addr, with bits [1:0] forced to 0.
REQ-016 SHALL implement FSM states FETCH (imem_req=1) and BUF (fetched word held in a one-entry skid buffer, imem_req=0).
REQ-017 In FETCH, on imem_ack with stall=0 and flush=0, SHALL load IF/ID with {fpc, imem_rdata, 1} and advance fpc.
REQ-018 In FETCH, on imem_ack with stall=1 or flush=1, SHALL store {fpc, imem_rdata} in the skid buffer, advance fpc and enter BUF.
REQ-019 In BUF, on the first cycle with stall=0 and flush=0, SHALL move the skid buffer into IF/ID and return to FETCH.
REQ-020 SHALL not issue a new request while in BUF; imem_req SHALL go high again the cycle after leaving BUF.
REQ-021 The fpc advance SHALL be fpc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), unless a redirect is pending, in which case the advance is to the pending target.
REQ-022 On redirect=1 with stall=0, SHALL latch NPC into a pending-target register, set pending, and clear pending at the next fpc advance, preserving the one-instruction delay slot.
REQ-023 A redirect asserted in the same cycle as an ack SHALL take effect on that advance (fpc <= NPC).
REQ-024 SHALL ignore redirect while stall=1, because ID holds the instruction and will reassert it.
REQ-025 A second redirect while pending=1 SHALL overwrite the target.
REQ-026 flush SHALL clear IF/ID to {PC_01 unchanged, 0, 0}, and SHALL take priority over stall and over any load in the same cycle.
REQ-027 With stall=1 and flush=0, IF/ID SHALL hold and no load SHALL occur.
REQ-028 With stall=0, flush=0 and no instruction available, IF/ID SHALL load a bubble (Instr_01=0, valid_01=0).
REQ-029 Latency from imem_ack to Instr_01 valid SHALL be 1 cycle when not stalled; sustained throughput SHALL be 1 instruction per ack.
REQ-030 Outputs SHALL come from registers only, with no combinational path from input to output except imem_addr from fpc.

Reset
REQ-031 While reset=0: fpc=RESET_PC, state=FETCH, pending=0, PC_01=RESET_PC, Instr_01=0, valid_01=0, skid buffer cleared.
REQ-032 imem_req SHALL be 0 while reset=0 and 1 in the first cycle after release.
REQ-033 Reset during an outstanding request SHALL abandon it; a late ack in reset is ignored.

Structure
REQ-034 RESET_PC, the NOP encoding (32'h0) and the FSM state encoding SHALL live in the shared pipeline package.
REQ-035 The IF/ID register SHALL be a sub-module if_id_reg (ports: stall, flush, load data, PC_01/Instr_01/valid_01).

Verification
REQ-036 Reset release with ack every cycle -> imem_addr 3000,3004,3008; Instr_01 follows one cycle behind; valid_01=1.
REQ-037 Ack at addr 3008 with stall=1 for 3 cycles -> state BUF, imem_req=0, IF/ID holds 3004; after stall drops, PC_01=3008, then fetch 300C.
REQ-038 redirect=1, NPC=3100 while fetching 300C -> delay slot 300C delivered, next imem_addr=3100.
REQ-039 flush together with stall and ack at 3010 -> Instr_01=0, valid_01=0; 3010 delivered from BUF on the next unstalled cycle.
REQ-040 reset=0 asserted mid-request at 3020 with a late ack -> PC_01=3000, valid_01=0, first post-reset fetch at 3000.
REQ-041 fpc=FFFF_FFFC acked -> next imem_addr=0000_0000.
